ima_adpcm_enc: RTL and testbench
================================

Name: ima_adpcm_enc

Overview:
- IMA ADPCM encoder: converts 16-bit signed linear PCM samples to 4-bit ADPCM nibbles.
- Produces exactly the nibble stream that ima_adpcm_dec consumes.
- Internally tracks the decoder's reconstruction: 19-bit predictor with 3 fractional bits, same step table, same saturation rules.
- Exports predictor and step index so they can be carried into ima_adpcm_dec's state-load port.

Parameters:
None (widths fixed by the IMA algorithm).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
inSamp  in  16  signed input sample
inValid  in  1  input sample valid
inReady  out  1  encoder can accept a sample (combinational: state==IDLE)
inPredictSamp  in  16  predictor load value (loaded as {inPredictSamp,3'b0})
inStepIndex  in  7  step index load value, 0..88
inStateLoad  in  1  load internal state; priority over inValid
outPCM  out  4  ADPCM nibble, bit3 = sign
outValid  out  1  one-cycle pulse, outPCM valid
outPredictSamp  out  16  predictor[18:3], current internal state
outStepIndex  out  7  current step index

Behaviour:
- Reset (reset==0):
  - predictor=0, stepIndex=0, stepSize=7, state=IDLE.
  - outPCM=0, outValid=0; inReady=1 after release.
- FSM states: IDLE -> B2 -> B1 -> B0 -> UPD -> WAIT -> IDLE.
- IDLE, on inValid&inReady at edge T:
  - diff = {inSamp,3'b0} - predictor, computed at 20 bits signed.
  - Register sign = diff<0 and mag = |diff| (20b unsigned).
  - Go to B2.
- B2 (edge T+1): if mag >= stepSize<<3 then b2=1, mag -= stepSize<<3.
- B1 (edge T+2): same test and subtract using stepSize<<2.
- B0 (edge T+3): b0 = (mag >= stepSize<<1).
- UPD (edge T+4):
  - dequant = stepSize*(8*b2 + 4*b1 + 2*b0 + 1), in 1/8 units; bit-identical to the decoder.
  - prePred = predictor ± dequant at 20 bits (subtract when sign=1).
  - Saturate to 19-bit signed: min {1,18'b0}, max {0,18'h3FFFF}.
  - stepIndex += delta, where delta = -1 for code[2:0]=0..3 and +2/+4/+6/+8 for code[2:0]=4/5/6/7; clamp to 0..88.
  - outPCM = {sign,b2,b1,b0}; outValid=1 for exactly one cycle.
- WAIT (edge T+5): stepSize lookup register reloads from the new stepIndex; go to IDLE.
- Throughput and latency:
  - inReady high again at T+6, so maximum throughput is 1 sample per 6 cycles.
  - Latency from accept edge to outValid edge is 4 cycles.
- stepSize is a registered lookup of stepIndex, updated every cycle; table identical to ima_adpcm_dec, index 0..88 -> 7..32767, out-of-range index -> 32767.
- Zero difference encodes sign=0.
- Output side has no backpressure; outPCM holds its value until the next UPD.
- inValid while inReady=0 is ignored; the sample is not captured.
- inStateLoad=1 in any state:
  - Loads predictor={inPredictSamp,3'b0} and stepIndex=inStepIndex.
  - Aborts any in-flight sample; no outValid for it.
  - Next state is WAIT, so stepSize refreshes before the next accept.
- inStateLoad and inValid in the same cycle: load wins, sample dropped.
- Reset mid-operation aborts immediately and returns to reset values.
- outPredictSamp/outStepIndex are direct register outputs; a decoder loaded with them reproduces subsequent samples exactly (fractional bits zeroed on both sides).

Test Plan:
1. Reset, inSamp=0x0000 -> outPCM=0x0, predictor=7 (outPredictSamp=0x0000), outStepIndex=0 (clamped), outValid 4 cycles after accept.
2. Reset, inSamp=100 -> mag=800 vs 56/28/14 gives outPCM=0x7; predictor=105 (outPredictSamp=13); outStepIndex=8; next stepSize=16.
3. Reset, inSamp=0xFF9C (-100) -> outPCM=0xF, predictor=0x7FF97, outPredictSamp=0xFFF2, outStepIndex=8.
4. Load inPredictSamp=0x7FF0, inStepIndex=88; inSamp=0x7FFF -> outPCM=0x0, predictor saturates to 0x3FFFF, outPredictSamp=0x7FFF, outStepIndex=87.
5. Load predictor=0, index=85; inSamp=0x7FFF -> mag=262136 gives outPCM=0x5; index 89 clamps to 88.
6. inValid held high for 30 cycles -> exactly 5 accepts, 6 cycles apart, 5 outValid pulses; inStateLoad pulsed at B1 -> no outValid, state loaded, inReady high 2 cycles later. Feed an encoded random 1000-sample stream into ima_adpcm_dec -> decoder predictor matches encoder predictor every sample.

Source files
------------

// File: rtl/ima_adpcm_enc.sv
// IMA ADPCM encoder: 16-bit signed PCM in, 4-bit ADPCM nibble out.
// Tracks the decoder's reconstruction exactly (19-bit predictor with
// 3 fractional bits, shared step table and saturation) so the exported
// predictor/step index can seed a decoder's state-load port.
module ima_adpcm_enc (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] inSamp,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] inPredictSamp,
  input  logic [6:0]  inStepIndex,
  input  logic        inStateLoad,
  output logic [3:0]  outPCM,
  output logic        outValid,
  output logic [15:0] outPredictSamp,
  output logic [6:0]  outStepIndex
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B2,
    S_B1,
    S_B0,
    S_UPD,
    S_WAIT
  } state_e;

  state_e      state_q;
  logic [18:0] predictor_q;
  logic [6:0]  step_index_q;
  logic [14:0] step_size_q;
  logic        sign_q;
  logic [19:0] mag_q;
  logic        b2_q;
  logic        b1_q;
  logic        b0_q;
  logic [3:0]  pcm_q;
  logic        out_valid_q;

  logic [19:0] diff;
  logic [19:0] mag_in;
  logic [19:0] thr8;
  logic [19:0] thr4;
  logic [19:0] thr2;
  logic [19:0] dequant;
  logic [19:0] pre_pred;
  logic [18:0] pred_d;
  logic [8:0]  idx_sum;
  logic [6:0]  index_d;

  // Step table shared with the decoder; indices past 88 read as the top entry.
  function automatic logic [14:0] step_lut(input logic [6:0] idx);
    logic [14:0] s;
    case (idx)
      7'd0:  s = 15'd7;
      7'd1:  s = 15'd8;
      7'd2:  s = 15'd9;
      7'd3:  s = 15'd10;
      7'd4:  s = 15'd11;
      7'd5:  s = 15'd12;
      7'd6:  s = 15'd13;
      7'd7:  s = 15'd14;
      7'd8:  s = 15'd16;
      7'd9:  s = 15'd17;
      7'd10: s = 15'd19;
      7'd11: s = 15'd21;
      7'd12: s = 15'd23;
      7'd13: s = 15'd25;
      7'd14: s = 15'd28;
      7'd15: s = 15'd31;
      7'd16: s = 15'd34;
      7'd17: s = 15'd37;
      7'd18: s = 15'd41;
      7'd19: s = 15'd45;
      7'd20: s = 15'd50;
      7'd21: s = 15'd55;
      7'd22: s = 15'd60;
      7'd23: s = 15'd66;
      7'd24: s = 15'd73;
      7'd25: s = 15'd80;
      7'd26: s = 15'd88;
      7'd27: s = 15'd97;
      7'd28: s = 15'd107;
      7'd29: s = 15'd118;
      7'd30: s = 15'd130;
      7'd31: s = 15'd143;
      7'd32: s = 15'd157;
      7'd33: s = 15'd173;
      7'd34: s = 15'd190;
      7'd35: s = 15'd209;
      7'd36: s = 15'd230;
      7'd37: s = 15'd253;
      7'd38: s = 15'd279;
      7'd39: s = 15'd307;
      7'd40: s = 15'd337;
      7'd41: s = 15'd371;
      7'd42: s = 15'd408;
      7'd43: s = 15'd449;
      7'd44: s = 15'd494;
      7'd45: s = 15'd544;
      7'd46: s = 15'd598;
      7'd47: s = 15'd658;
      7'd48: s = 15'd724;
      7'd49: s = 15'd796;
      7'd50: s = 15'd876;
      7'd51: s = 15'd963;
      7'd52: s = 15'd1060;
      7'd53: s = 15'd1166;
      7'd54: s = 15'd1282;
      7'd55: s = 15'd1411;
      7'd56: s = 15'd1552;
      7'd57: s = 15'd1707;
      7'd58: s = 15'd1878;
      7'd59: s = 15'd2066;
      7'd60: s = 15'd2272;
      7'd61: s = 15'd2499;
      7'd62: s = 15'd2749;
      7'd63: s = 15'd3024;
      7'd64: s = 15'd3327;
      7'd65: s = 15'd3660;
      7'd66: s = 15'd4026;
      7'd67: s = 15'd4428;
      7'd68: s = 15'd4871;
      7'd69: s = 15'd5358;
      7'd70: s = 15'd5894;
      7'd71: s = 15'd6484;
      7'd72: s = 15'd7132;
      7'd73: s = 15'd7845;
      7'd74: s = 15'd8630;
      7'd75: s = 15'd9493;
      7'd76: s = 15'd10442;
      7'd77: s = 15'd11487;
      7'd78: s = 15'd12635;
      7'd79: s = 15'd13899;
      7'd80: s = 15'd15289;
      7'd81: s = 15'd16818;
      7'd82: s = 15'd18500;
      7'd83: s = 15'd20350;
      7'd84: s = 15'd22385;
      7'd85: s = 15'd24623;
      7'd86: s = 15'd27086;
      7'd87: s = 15'd29794;
      default: s = 15'd32767;
    endcase
    return s;
  endfunction

  // Difference/magnitude at accept, quantiser thresholds, reconstruction and index update.
  always_comb begin
    diff     = {inSamp[15], inSamp, 3'b000} - {predictor_q[18], predictor_q};
    mag_in   = diff[19] ? (20'd0 - diff) : diff;
    thr8     = {2'b00, step_size_q, 3'b000};
    thr4     = {3'b000, step_size_q, 2'b00};
    thr2     = {4'b0000, step_size_q, 1'b0};
    // {b2,b1,b0,1} is 8*b2 + 4*b1 + 2*b0 + 1, the decoder's dequant multiplier
    dequant  = {5'b0, step_size_q} * {16'b0, b2_q, b1_q, b0_q, 1'b1};
    pre_pred = sign_q ? ({predictor_q[18], predictor_q} - dequant)
                      : ({predictor_q[18], predictor_q} + dequant);
    case (pre_pred[19:18])
      2'b01:   pred_d = 19'h3FFFF;
      2'b10:   pred_d = 19'h40000;
      default: pred_d = pre_pred[18:0];
    endcase
    // 0x1FF is -1 in 9 bits; bit 8 can only be set by that underflow
    idx_sum = {2'b00, step_index_q} +
              (b2_q ? ({6'b0, b1_q, b0_q, 1'b0} + 9'd2) : 9'h1FF);
    if (idx_sum[8]) begin
      index_d = '0;
    end else if (idx_sum > 9'd88) begin
      index_d = 7'd88;
    end else begin
      index_d = idx_sum[6:0];
    end
  end

  // Step size is a registered lookup of the current index, refreshed every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      step_size_q <= 15'd7;
    end else begin
      step_size_q <= step_lut(step_index_q);
    end
  end

  // Bit-serial quantiser FSM; state load overrides everything and aborts in-flight work.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      predictor_q  <= '0;
      step_index_q <= '0;
      sign_q       <= 1'b0;
      mag_q        <= '0;
      b2_q         <= 1'b0;
      b1_q         <= 1'b0;
      b0_q         <= 1'b0;
      pcm_q        <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (inStateLoad) begin
        predictor_q  <= {inPredictSamp, 3'b000};
        step_index_q <= inStepIndex;
        state_q      <= S_WAIT;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (inValid) begin
              sign_q  <= diff[19];
              mag_q   <= mag_in;
              state_q <= S_B2;
            end
          end
          S_B2: begin
            b2_q    <= (mag_q >= thr8);
            mag_q   <= (mag_q >= thr8) ? (mag_q - thr8) : mag_q;
            state_q <= S_B1;
          end
          S_B1: begin
            b1_q    <= (mag_q >= thr4);
            mag_q   <= (mag_q >= thr4) ? (mag_q - thr4) : mag_q;
            state_q <= S_B0;
          end
          S_B0: begin
            b0_q    <= (mag_q >= thr2);
            state_q <= S_UPD;
          end
          S_UPD: begin
            predictor_q  <= pred_d;
            step_index_q <= index_d;
            pcm_q        <= {sign_q, b2_q, b1_q, b0_q};
            out_valid_q  <= 1'b1;
            state_q      <= S_WAIT;
          end
          S_WAIT: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign inReady        = (state_q == S_IDLE);
  assign outPCM         = pcm_q;
  assign outValid       = out_valid_q;
  assign outPredictSamp = predictor_q[18:3];
  assign outStepIndex   = step_index_q;

endmodule

// File: tb/tb_ima_adpcm_enc.sv
// Testbench for ima_adpcm_enc: directed corner cases plus a random stream,
// checked against an arithmetic IMA encoder model and a decoder model.
module tb_ima_adpcm_enc;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] inSamp;
  logic        inValid;
  logic        inReady;
  logic [15:0] inPredictSamp;
  logic [6:0]  inStepIndex;
  logic        inStateLoad;
  logic [3:0]  outPCM;
  logic        outValid;
  logic [15:0] outPredictSamp;
  logic [6:0]  outStepIndex;

  int total = 0;
  int bad   = 0;

  int mpred = 0;
  int midx  = 0;
  int dpred = 0;
  int didx  = 0;

  int steptab [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
    19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
    130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
    876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
    2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
    5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
    15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767};
  int adj [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  ima_adpcm_enc dut (
    .clock          (clock),
    .reset          (reset),
    .inSamp         (inSamp),
    .inValid        (inValid),
    .inReady        (inReady),
    .inPredictSamp  (inPredictSamp),
    .inStepIndex    (inStepIndex),
    .inStateLoad    (inStateLoad),
    .outPCM         (outPCM),
    .outValid       (outValid),
    .outPredictSamp (outPredictSamp),
    .outStepIndex   (outStepIndex)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [15:0] top16(input int p);
    int t;
    t = p >>> 3;
    return t[15:0];
  endfunction

  // Reference encoder: plain IMA arithmetic on integers.
  task automatic model_enc(input logic [15:0] s, output int code);
    int sv, diff, mag, step, dq, b2, b1, b0, sg;
    sv   = int'($signed(s));
    diff = sv * 8 - mpred;
    sg   = (diff < 0) ? 1 : 0;
    mag  = sg ? -diff : diff;
    step = (midx <= 88) ? steptab[midx] : 32767;
    b2 = (mag >= 8 * step) ? 1 : 0;
    if (b2 != 0) mag -= 8 * step;
    b1 = (mag >= 4 * step) ? 1 : 0;
    if (b1 != 0) mag -= 4 * step;
    b0 = (mag >= 2 * step) ? 1 : 0;
    code  = sg * 8 + b2 * 4 + b1 * 2 + b0;
    dq    = step * (8 * b2 + 4 * b1 + 2 * b0 + 1);
    mpred = clamp(sg ? mpred - dq : mpred + dq, -262144, 262143);
    midx  = clamp(midx + adj[code & 7], 0, 88);
  endtask

  // Reference decoder fed with the nibbles the DUT actually emits.
  task automatic dec_step(input logic [3:0] c);
    int step, dq, mag3;
    step  = (didx <= 88) ? steptab[didx] : 32767;
    mag3  = int'(c[2:0]);
    dq    = step * (2 * mag3 + 1);
    dpred = clamp(c[3] ? dpred - dq : dpred + dq, -262144, 262143);
    didx  = clamp(didx + adj[mag3], 0, 88);
  endtask

  task automatic do_reset;
    reset       = 1'b0;
    inValid     = 1'b0;
    inStateLoad = 1'b0;
    #1;
    check("rst_outValid", outValid, 1'b0);
    check("rst_outPCM", outPCM, 4'h0);
    check("rst_pred", outPredictSamp, 16'h0000);
    check("rst_idx", outStepIndex, 7'd0);
    check("rst_ready", inReady, 1'b1);
    tick;
    tick;
    reset = 1'b1;
    mpred = 0;
    midx  = 0;
    dpred = 0;
    didx  = 0;
  endtask

  task automatic load_state(input logic [15:0] p, input logic [6:0] idx);
    inPredictSamp = p;
    inStepIndex   = idx;
    inStateLoad   = 1'b1;
    tick;
    inStateLoad = 1'b0;
    check("load_pred", outPredictSamp, p);
    check("load_idx", outStepIndex, idx);
    check("load_busy", inReady, 1'b0);
    check("load_novalid", outValid, 1'b0);
    tick;
    check("load_ready", inReady, 1'b1);
    mpred = int'($signed(p)) * 8;
    midx  = int'(idx);
    dpred = mpred;
    didx  = midx;
  endtask

  // Push one sample through the DUT and compare against the given expectations.
  task automatic run_sample(input logic [15:0] s, input logic [3:0] ec,
                            input logic [15:0] eps, input logic [6:0] eidx);
    int n;
    int lat;
    n = 0;
    while (!inReady && n < 20) begin
      tick;
      n++;
    end
    check("wait_ready", inReady, 1'b1);
    inSamp  = s;
    inValid = 1'b1;
    tick;
    // A busy-time inValid with a different sample must be ignored.
    inSamp  = ~s;
    lat = 0;
    while (lat < 12) begin
      tick;
      inValid = 1'b0;
      lat++;
      if (outValid) break;
    end
    check("latency", lat, 4);
    check("pcm", outPCM, ec);
    check("pred", outPredictSamp, eps);
    check("idx", outStepIndex, eidx);
    dec_step(outPCM);
    check("dec_pred", top16(dpred), outPredictSamp);
    check("dec_idx", didx, outStepIndex);
    tick;
    check("pulse_1cyc", outValid, 1'b0);
    check("pcm_hold", outPCM, ec);
    check("ready_again", inReady, 1'b1);
  endtask

  task automatic rand_sample(input logic [15:0] s);
    int c;
    model_enc(s, c);
    run_sample(s, c[3:0], top16(mpred), midx[6:0]);
  endtask

  initial begin
    int c;
    int acc_cnt;
    int pulse_cnt;
    int last_acc;
    int cur;
    int qc[$];
    int qp[$];
    int qi[$];
    reset         = 1'b0;
    inSamp        = '0;
    inValid       = 1'b0;
    inPredictSamp = '0;
    inStepIndex   = '0;
    inStateLoad   = 1'b0;

    // 1: zero input from reset
    do_reset;
    model_enc(16'h0000, c);
    run_sample(16'h0000, 4'h0, 16'h0000, 7'd0);

    // 2: +100 from reset
    do_reset;
    model_enc(16'd100, c);
    run_sample(16'd100, 4'h7, 16'd13, 7'd8);

    // 3: -100 from reset
    do_reset;
    model_enc(16'hFF9C, c);
    run_sample(16'hFF9C, 4'hF, 16'hFFF2, 7'd8);

    // 4: positive saturation at top index
    load_state(16'h7FF0, 7'd88);
    model_enc(16'h7FFF, c);
    run_sample(16'h7FFF, 4'h0, 16'h7FFF, 7'd87);

    // 5: index clamp at 88
    load_state(16'h0000, 7'd85);
    model_enc(16'h7FFF, c);
    run_sample(16'h7FFF, 4'h5, 16'h7FFF, 7'd88);

    // Negative saturation
    load_state(16'h8010, 7'd88);
    model_enc(16'h8000, c);
    run_sample(16'h8000, 4'h8, 16'h8000, 7'd87);

    // Throughput with inValid held high
    acc_cnt   = 0;
    pulse_cnt = 0;
    last_acc  = -1;
    for (int k = 0; k < 30; k++) begin
      inSamp  = 16'($urandom);
      inValid = 1'b1;
      if (inReady) begin
        acc_cnt++;
        if (last_acc >= 0) check("tp_gap", k - last_acc, 6);
        last_acc = k;
        model_enc(inSamp, c);
        qc.push_back(c);
        qp.push_back(int'(top16(mpred)));
        qi.push_back(midx);
      end
      tick;
      if (outValid) begin
        pulse_cnt++;
        check("tp_pending", (qc.size() > 0), 1'b1);
        if (qc.size() > 0) begin
          check("tp_pcm", outPCM, qc.pop_front());
          check("tp_pred", outPredictSamp, qp.pop_front());
          check("tp_idx", outStepIndex, qi.pop_front());
          dec_step(outPCM);
          check("tp_dec_pred", top16(dpred), outPredictSamp);
        end
      end
    end
    inValid = 1'b0;
    check("tp_accepts", acc_cnt, 5);
    check("tp_pulses", pulse_cnt, 5);
    tick;

    // State load at B1 aborts the sample in flight
    inSamp  = 16'h1234;
    inValid = 1'b1;
    tick;
    inValid = 1'b0;
    tick;
    inPredictSamp = 16'hF000;
    inStepIndex   = 7'd40;
    inStateLoad   = 1'b1;
    tick;
    inStateLoad = 1'b0;
    check("abort_pred", outPredictSamp, 16'hF000);
    check("abort_idx", outStepIndex, 7'd40);
    check("abort_busy", inReady, 1'b0);
    pulse_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) check("abort_ready", inReady, 1'b1);
      if (outValid) pulse_cnt++;
      tick;
    end
    check("abort_nopulse", pulse_cnt, 0);
    mpred = -4096 * 8;
    midx  = 40;
    dpred = mpred;
    didx  = midx;
    rand_sample(16'hF100);

    // Load and valid in the same cycle: load wins
    inSamp        = 16'h4000;
    inValid       = 1'b1;
    inPredictSamp = 16'h0100;
    inStepIndex   = 7'd20;
    inStateLoad   = 1'b1;
    tick;
    inValid     = 1'b0;
    inStateLoad = 1'b0;
    check("lv_pred", outPredictSamp, 16'h0100);
    check("lv_busy", inReady, 1'b0);
    pulse_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (outValid) pulse_cnt++;
      tick;
    end
    check("lv_nopulse", pulse_cnt, 0);
    mpred = 256 * 8;
    midx  = 20;
    dpred = mpred;
    didx  = midx;
    rand_sample(16'h0180);

    // Reset in the middle of a sample
    inSamp  = 16'h2000;
    inValid = 1'b1;
    tick;
    inValid = 1'b0;
    tick;
    tick;
    do_reset;
    rand_sample(16'h0000);

    // Random stream, checked sample by sample against both models
    cur = 0;
    for (int k = 0; k < 1000; k++) begin
      if ((k % 50) == 49) begin
        cur = int'($signed(16'($urandom)));
      end else begin
        cur = clamp(cur + int'($urandom_range(0, 4000)) - 2000, -32768, 32767);
      end
      rand_sample(cur[15:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
